// File: rtl/algo_1r3w_rdresp_mon.sv
// ---------------------------------------------------------------------------
// algo_1r3w_rdresp_mon
//
// Read-response monitor and error logger for the 1R3W multi-bank memory
// algorithm. It tracks every accepted read through an RD_DELAY-deep pipe and
// flags any response that does not arrive exactly RD_DELAY cycles later. It
// counts single/double ECC events with saturating counters and latches the
// first failing address, upgrading it once if a later double error occurs.
//
// Optional feature macro: ALGO_1R3W_RDMON_PADR_EN
//   defined   -> the physical address of the latched error is captured
//   undefined -> first_err_padr is tied to 0
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   ready          in   algorithm ready; reads while low are not tracked
//   read           in   read issued to the algorithm
//   rd_adr         in   logical address of the issued read
//   rd_vld         in   read data valid from the algorithm
//   rd_serr        in   single-bit (corrected) error, qualified by rd_vld
//   rd_derr        in   uncorrectable error, qualified by rd_vld
//   rd_padr        in   physical address of the returning read
//   clr            in   clear counters, first-error latch and proto_err
//   serr_irq_en    in   include single-bit errors in irq
//   serr_cnt       out  saturating single-error count
//   derr_cnt       out  saturating double-error count
//   first_err_vld  out  first-error latch holds an entry
//   first_err_dbl  out  latched entry is a double error
//   first_err_adr  out  logical address of the latched entry
//   first_err_padr out  physical address of the latched entry
//   proto_err      out  sticky latency/protocol violation
//   irq            out  level interrupt
// ---------------------------------------------------------------------------
module algo_1r3w_rdresp_mon #(
    parameter int BITADDR  = 13,
    parameter int BITPADR  = 16,
    parameter int RD_DELAY = 3,
    parameter int CNTW     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic               read,
    input  logic [BITADDR-1:0] rd_adr,
    input  logic               rd_vld,
    input  logic               rd_serr,
    input  logic               rd_derr,
    input  logic [BITPADR-1:0] rd_padr,
    input  logic               clr,
    input  logic               serr_irq_en,
    output logic [CNTW-1:0]    serr_cnt,
    output logic [CNTW-1:0]    derr_cnt,
    output logic               first_err_vld,
    output logic               first_err_dbl,
    output logic [BITADDR-1:0] first_err_adr,
    output logic [BITPADR-1:0] first_err_padr,
    output logic               proto_err,
    output logic               irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHELD = 2'd1,
        DHELD = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             base_state;
    state_t             next_state;
    logic               cap;
    logic               en_q;

    logic [RD_DELAY-1:0] vld_pipe;
    logic [BITADDR-1:0]  adr_pipe [RD_DELAY];

    logic               exp_vld;
    logic [BITADDR-1:0] exp_adr;
    logic               serr_ev;
    logic               derr_ev;

    assign exp_vld = vld_pipe[RD_DELAY-1];
    assign exp_adr = adr_pipe[RD_DELAY-1];

    // Double error wins when both flags are set; nothing counts without rd_vld.
    assign serr_ev = rd_vld & rd_serr & ~rd_derr;
    assign derr_ev = rd_vld & rd_derr;

    // NOTE: the address pipe carries data only; its valid bits decide whether
    // an entry means anything, so it needs no reset and stays a plain shifter.
    always_ff @(posedge clk) begin
        adr_pipe[0] <= rd_adr;
        for (int i = 1; i < RD_DELAY; i++) begin
            adr_pipe[i] <= adr_pipe[i-1];
        end
    end

    // A same-cycle clr is applied first, so the event is evaluated from IDLE.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        base_state = clr ? IDLE : state;
        next_state = base_state;
        cap        = 1'b0;
        case (base_state)
            IDLE: begin
                if (derr_ev) begin
                    next_state = DHELD;
                    cap        = 1'b1;
                end else if (serr_ev) begin
                    next_state = SHELD;
                    cap        = 1'b1;
                end
            end
            SHELD: begin
                if (derr_ev) begin
                    next_state = DHELD;
                    cap        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe      <= '0;
            state         <= IDLE;
            serr_cnt      <= '0;
            derr_cnt      <= '0;
            first_err_adr <= '0;
            proto_err     <= 1'b0;
            en_q          <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe, read & ready};
            state    <= next_state;
            en_q     <= serr_irq_en;

            if (clr) begin
                serr_cnt <= {{(CNTW-1){1'b0}}, serr_ev};
                derr_cnt <= {{(CNTW-1){1'b0}}, derr_ev};
            end else begin
                if (serr_ev && serr_cnt != CNT_MAX) serr_cnt <= serr_cnt + 1'b1;
                if (derr_ev && derr_cnt != CNT_MAX) derr_cnt <= derr_cnt + 1'b1;
            end

            // Without a tracked read there is no logical address to report.
            if (cap)      first_err_adr <= exp_vld ? exp_adr : '0;
            else if (clr) first_err_adr <= '0;

            proto_err <= (proto_err & ~clr) | (rd_vld ^ exp_vld);
        end
    end

`ifdef ALGO_1R3W_RDMON_PADR_EN
    always_ff @(posedge clk) begin
        if (rst)      first_err_padr <= '0;
        else if (cap) first_err_padr <= rd_padr;
        else if (clr) first_err_padr <= '0;
    end
`else
    logic unused_padr;
    assign unused_padr    = ^rd_padr;
    assign first_err_padr = '0;
`endif

    assign first_err_vld = (state != IDLE);
    assign first_err_dbl = (state == DHELD);
    assign irq           = (state == DHELD) | ((state == SHELD) & en_q);

endmodule

// File: tb/tb_algo_1r3w_rdresp_mon.sv
// ---------------------------------------------------------------------------
// tb_algo_1r3w_rdresp_mon
//
// Bench for algo_1r3w_rdresp_mon. A default-width instance (CNTW=16) and a
// narrow instance (CNTW=4, for saturation) share all stimulus. Every issued
// read pushes an expectation {due cycle, address} into a queue; when that
// cycle comes the entry is popped and drives a small reference model of the
// counters, first-error latch, protocol flag and interrupt.
// ---------------------------------------------------------------------------
module tb_algo_1r3w_rdresp_mon;

    localparam int D = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ready, read, rd_vld, rd_serr, rd_derr, clr, serr_irq_en;
    logic [12:0] rd_adr;
    logic [15:0] rd_padr;

    logic [15:0] serr_cnt, derr_cnt, first_err_padr;
    logic        first_err_vld, first_err_dbl, proto_err, irq;
    logic [12:0] first_err_adr;

    logic [3:0]  s_serr_cnt, s_derr_cnt;
    logic        s_first_err_vld, s_first_err_dbl, s_proto_err, s_irq;
    logic [12:0] s_first_err_adr;
    logic [15:0] s_first_err_padr;

    algo_1r3w_rdresp_mon #(.BITADDR(13), .BITPADR(16), .RD_DELAY(D), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .ready(ready), .read(read), .rd_adr(rd_adr),
        .rd_vld(rd_vld), .rd_serr(rd_serr), .rd_derr(rd_derr), .rd_padr(rd_padr),
        .clr(clr), .serr_irq_en(serr_irq_en),
        .serr_cnt(serr_cnt), .derr_cnt(derr_cnt),
        .first_err_vld(first_err_vld), .first_err_dbl(first_err_dbl),
        .first_err_adr(first_err_adr), .first_err_padr(first_err_padr),
        .proto_err(proto_err), .irq(irq)
    );

    algo_1r3w_rdresp_mon #(.BITADDR(13), .BITPADR(16), .RD_DELAY(D), .CNTW(4)) u_sat (
        .clk(clk), .rst(rst), .ready(ready), .read(read), .rd_adr(rd_adr),
        .rd_vld(rd_vld), .rd_serr(rd_serr), .rd_derr(rd_derr), .rd_padr(rd_padr),
        .clr(clr), .serr_irq_en(serr_irq_en),
        .serr_cnt(s_serr_cnt), .derr_cnt(s_derr_cnt),
        .first_err_vld(s_first_err_vld), .first_err_dbl(s_first_err_dbl),
        .first_err_adr(s_first_err_adr), .first_err_padr(s_first_err_padr),
        .proto_err(s_proto_err), .irq(s_irq)
    );

    typedef struct {
        int          due;
        logic [12:0] adr;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model (state: 0 idle, 1 single held, 2 double held)
    int          m_serr, m_derr, m_state;
    logic [12:0] m_adr;
    logic [15:0] m_padr;
    logic        m_proto, m_en_q;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    // One clock: drive inputs, advance the model, then compare all outputs.
    task automatic tick(input logic i_rst, input logic i_clr, input logic i_ready,
                        input logic i_read, input logic [12:0] i_adr,
                        input logic i_vld, input logic i_serr, input logic i_derr,
                        input logic [15:0] i_padr);
        logic        hit;
        logic [12:0] e_adr;
        logic        sev, dev;
        logic [15:0] exp_padr;
        logic        exp_irq;
        rst = i_rst; clr = i_clr; ready = i_ready; read = i_read; rd_adr = i_adr;
        rd_vld = i_vld; rd_serr = i_serr; rd_derr = i_derr; rd_padr = i_padr;

        if (i_rst) begin
            sb.delete();
            m_serr = 0; m_derr = 0; m_state = 0; m_adr = '0; m_padr = '0;
            m_proto = 1'b0; m_en_q = 1'b0;
        end else begin
            hit   = 1'b0;
            e_adr = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                hit   = 1'b1;
                e_adr = sb[0].adr;
                void'(sb.pop_front());
            end
            if (i_read && i_ready) sb.push_back('{cyc + D, i_adr});
            sev = i_vld & i_serr & ~i_derr;
            dev = i_vld & i_derr;
            if (i_clr) begin
                m_serr = 0; m_derr = 0; m_state = 0; m_adr = '0; m_padr = '0;
                m_proto = 1'b0;
            end
            if (sev) m_serr++;
            if (dev) m_derr++;
            if ((m_state == 0 && (sev || dev)) || (m_state == 1 && dev)) begin
                m_state = dev ? 2 : 1;
                m_adr   = e_adr;
                m_padr  = i_padr;
            end
            if (i_vld != hit) m_proto = 1'b1;
            m_en_q = serr_irq_en;
        end

        @(posedge clk);
        #1;
        cyc++;

`ifdef ALGO_1R3W_RDMON_PADR_EN
        exp_padr = m_padr;
`else
        exp_padr = 16'h0;
`endif
        exp_irq = (m_state == 2) || (m_state == 1 && m_en_q);

        checks++;
        if (serr_cnt !== sat16(m_serr)) begin
            errors++;
            $display("FAIL serr_cnt cyc=%0d got %0d want %0d", cyc, serr_cnt, sat16(m_serr));
        end
        checks++;
        if (derr_cnt !== sat16(m_derr)) begin
            errors++;
            $display("FAIL derr_cnt cyc=%0d got %0d want %0d", cyc, derr_cnt, sat16(m_derr));
        end
        checks++;
        if (s_serr_cnt !== sat4(m_serr) || s_derr_cnt !== sat4(m_derr)) begin
            errors++;
            $display("FAIL sat_cnt cyc=%0d got s=%0d d=%0d want s=%0d d=%0d", cyc,
                     s_serr_cnt, s_derr_cnt, sat4(m_serr), sat4(m_derr));
        end
        checks++;
        if (first_err_vld !== (m_state != 0) || first_err_dbl !== (m_state == 2)) begin
            errors++;
            $display("FAIL first_err_state cyc=%0d got vld=%0b dbl=%0b want state %0d",
                     cyc, first_err_vld, first_err_dbl, m_state);
        end
        checks++;
        if (first_err_adr !== m_adr || first_err_padr !== exp_padr) begin
            errors++;
            $display("FAIL first_err_addr cyc=%0d got adr=%h padr=%h want adr=%h padr=%h",
                     cyc, first_err_adr, first_err_padr, m_adr, exp_padr);
        end
        checks++;
        if (proto_err !== m_proto) begin
            errors++;
            $display("FAIL proto_err cyc=%0d got %0b want %0b", cyc, proto_err, m_proto);
        end
        checks++;
        if (irq !== exp_irq) begin
            errors++;
            $display("FAIL irq cyc=%0d got %0b want %0b", cyc, irq, exp_irq);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_clr();
        tick(1'b0, 1'b1, 1'b1, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Single read answered exactly D cycles later.
    task automatic read_resp(input logic [12:0] a, input logic s, input logic d,
                             input logic [15:0] pa, input logic c_at_resp);
        tick(1'b0, 1'b0, 1'b1, 1'b1, a, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(D - 1);
        tick(1'b0, c_at_resp, 1'b1, 1'b0, 13'h0, 1'b1, s, d, pa);
    endtask

    // n reads on consecutive cycles, responses pipelined behind them.
    // mode 1: all serr; mode 2: serr/derr/clean by response index mod 3.
    task automatic stream(input int n, input logic [12:0] base, input int mode);
        for (int t = 0; t < n + D; t++) begin
            int   j;
            logic s, d;
            j = t - D;
            s = 1'b0;
            d = 1'b0;
            if (t >= D) begin
                if (mode == 1) s = 1'b1;
                if (mode == 2) begin
                    s = (j % 3 == 0);
                    d = (j % 3 == 1);
                end
            end
            tick(1'b0, 1'b0, 1'b1, (t < n), 13'(base + t), (t >= D), s, d, 16'(16'h1000 + j));
        end
    endtask

    task automatic test_reset();
        serr_irq_en = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if (serr_cnt !== 16'h0 || derr_cnt !== 16'h0 || proto_err !== 1'b0 ||
            irq !== 1'b0 || first_err_vld !== 1'b0 || first_err_adr !== 13'h0) begin
            errors++;
            $display("FAIL reset_state got s=%0d d=%0d p=%0b i=%0b v=%0b a=%h want all 0",
                     serr_cnt, derr_cnt, proto_err, irq, first_err_vld, first_err_adr);
        end
        idle(D + 1);
    endtask

    task automatic test_single_serr();
        serr_irq_en = 1'b1;
        read_resp(13'h0A5, 1'b1, 1'b0, 16'h1234, 1'b0);
        checks++;
        if (serr_cnt !== 16'd1 || first_err_adr !== 13'h0A5 || first_err_dbl !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL single_serr got cnt=%0d adr=%h dbl=%0b irq=%0b want 1 0a5 0 1",
                     serr_cnt, first_err_adr, first_err_dbl, irq);
        end
        serr_irq_en = 1'b0;
        idle(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL serr_irq_mask got %0b want 0", irq);
        end
        do_clr();
    endtask

    task automatic test_upgrade();
        serr_irq_en = 1'b0;
        read_resp(13'h010, 1'b1, 1'b0, 16'h0010, 1'b0);
        read_resp(13'h020, 1'b0, 1'b1, 16'h0020, 1'b0);
        read_resp(13'h030, 1'b0, 1'b1, 16'h0030, 1'b0);
        checks++;
        if (derr_cnt !== 16'd2 || first_err_adr !== 13'h020 || first_err_dbl !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL upgrade got d=%0d adr=%h dbl=%0b irq=%0b want 2 020 1 1",
                     derr_cnt, first_err_adr, first_err_dbl, irq);
        end
        do_clr();
        checks++;
        if (first_err_vld !== 1'b0 || first_err_adr !== 13'h0 || derr_cnt !== 16'h0) begin
            errors++;
            $display("FAIL clr_latch got v=%0b adr=%h d=%0d want 0 0 0",
                     first_err_vld, first_err_adr, derr_cnt);
        end
    endtask

    task automatic test_early_response();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 13'h040, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(D - 2);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 13'h0, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL early_resp got %0b want 1", proto_err);
        end
        idle(3);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky got %0b want 1", proto_err);
        end
        do_clr();
    endtask

    task automatic test_ready_gate();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 13'h060, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(D + 1);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL untracked_read got %0b want 0", proto_err);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1, 13'h060, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(D + 1);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL missing_resp got %0b want 1", proto_err);
        end
        do_clr();
    endtask

    task automatic test_back_to_back();
        serr_irq_en = 1'b1;
        stream(12, 13'h100, 2);
        checks++;
        if (serr_cnt !== 16'd4 || derr_cnt !== 16'd4 || first_err_adr !== 13'h101 ||
            first_err_dbl !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back got s=%0d d=%0d adr=%h dbl=%0b p=%0b want 4 4 101 1 0",
                     serr_cnt, derr_cnt, first_err_adr, first_err_dbl, proto_err);
        end
        do_clr();
    endtask

    task automatic test_saturation();
        stream(20, 13'h200, 1);
        checks++;
        if (s_serr_cnt !== 4'd15 || serr_cnt !== 16'd20) begin
            errors++;
            $display("FAIL saturation got narrow=%0d wide=%0d want 15 20", s_serr_cnt, serr_cnt);
        end
        do_clr();
    endtask

    task automatic test_clr_with_event();
        stream(5, 13'h300, 1);
        read_resp(13'h3AA, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        checks++;
        if (serr_cnt !== 16'd0 || derr_cnt !== 16'd1 || first_err_dbl !== 1'b1 ||
            first_err_adr !== 13'h3AA) begin
            errors++;
            $display("FAIL clr_event got s=%0d d=%0d dbl=%0b adr=%h want 0 1 1 3aa",
                     serr_cnt, derr_cnt, first_err_dbl, first_err_adr);
        end
        do_clr();
    endtask

    task automatic test_mid_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b1, 13'h050, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(D - 2);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 13'h0, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL resp_after_reset got %0b want 1", proto_err);
        end
        do_clr();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; ready = 1'b0; read = 1'b0; rd_adr = '0;
        rd_vld = 1'b0; rd_serr = 1'b0; rd_derr = 1'b0; rd_padr = '0; serr_irq_en = 1'b0;
        test_reset();
        test_single_serr();
        test_upgrade();
        test_early_response();
        test_ready_gate();
        test_back_to_back();
        test_saturation();
        test_clr_with_event();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
